// File: rtl/key_debounce.sv
// Push-button conditioner: synchronizes a raw active-low key, debounces press and
// release, and emits KEY_OK / KEY_Release pulses with optional hold-to-repeat.
//
// state        | meaning
// -------------+---------------------------------------------------------------
// IDLE         | key released and stable
// PRESS_WAIT   | key seen pressed, counting DEB_T stable cycles
// PRESSED      | press accepted; counting HOLD_T toward auto-repeat
// REPEAT       | auto-repeat active; KEY_OK every REP_T cycles
// RELEASE_WAIT | key seen released, counting DEB_T stable cycles
module key_debounce #(
  parameter logic [29:0] DEB_T     = 30'd1_000_000,
  parameter logic [29:0] HOLD_T    = 30'd25_000_000,
  parameter logic [29:0] REP_T     = 30'd5_000_000,
  parameter logic        REPEAT_EN = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       KEY_In,
  output logic       KEY_OK,
  output logic       KEY_Release,
  output logic       KEY_Level,
  output logic [7:0] Press_Cnt
);

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_PRESS_WAIT   = 3'd1,
    S_PRESSED      = 3'd2,
    S_REPEAT       = 3'd3,
    S_RELEASE_WAIT = 3'd4
  } state_t;

  localparam logic [29:0] DEB_M1  = DEB_T - 30'd1;
  localparam logic [29:0] HOLD_M1 = HOLD_T - 30'd1;
  localparam logic [29:0] REP_M1  = REP_T - 30'd1;

  state_t      state_q, state_d;
  logic        s1_q, s2_q;
  logic [29:0] cnt_q, cnt_d;
  logic [29:0] hold_q, hold_d;
  logic [29:0] rep_q, rep_d;
  logic        ok_q, ok_d;
  logic        rel_q, rel_d;
  logic        lvl_q, lvl_d;
  logic [7:0]  pcnt_q, pcnt_d;
  logic        p;

  // Key pin is asynchronous; only the second flop feeds the FSM.
  assign p = ~s2_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      rep_q   <= '0;
      ok_q    <= 1'b0;
      rel_q   <= 1'b0;
      lvl_q   <= 1'b0;
      pcnt_q  <= '0;
    end else begin
      s1_q    <= KEY_In;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      rep_q   <= rep_d;
      ok_q    <= ok_d;
      rel_q   <= rel_d;
      lvl_q   <= lvl_d;
      pcnt_q  <= pcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    rep_d   = rep_q;
    ok_d    = 1'b0;
    rel_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (p) begin
          state_d = S_PRESS_WAIT;
          cnt_d   = '0;
        end
      end

      S_PRESS_WAIT: begin
        if (!p) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_M1) begin
          state_d = S_PRESSED;
          hold_d  = '0;
          ok_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 30'd1;
        end
      end

      S_PRESSED: begin
        if (!p) begin
          state_d = S_RELEASE_WAIT;
          cnt_d   = '0;
        end else if (hold_q == HOLD_M1) begin
          // Without repeat the hold counter simply parks at its terminal value.
          if (REPEAT_EN) begin
            state_d = S_REPEAT;
            rep_d   = '0;
            ok_d    = 1'b1;
          end
        end else begin
          hold_d = hold_q + 30'd1;
        end
      end

      S_REPEAT: begin
        if (!p) begin
          state_d = S_RELEASE_WAIT;
          cnt_d   = '0;
        end else if (rep_q == REP_M1) begin
          rep_d = '0;
          ok_d  = 1'b1;
        end else begin
          rep_d = rep_q + 30'd1;
        end
      end

      S_RELEASE_WAIT: begin
        // A bounce back to pressed resumes the hold without a new KEY_OK.
        if (p) begin
          state_d = S_PRESSED;
          hold_d  = '0;
        end else if (cnt_q == DEB_M1) begin
          state_d = S_IDLE;
          rel_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 30'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        hold_d  = '0;
        rep_d   = '0;
      end
    endcase
  end

  always_comb begin
    lvl_d  = (state_d == S_PRESSED) || (state_d == S_REPEAT) ||
             (state_d == S_RELEASE_WAIT);
    pcnt_d = pcnt_q + {7'd0, ok_d};
  end

  assign KEY_OK      = ok_q;
  assign KEY_Release = rel_q;
  assign KEY_Level   = lvl_q;
  assign Press_Cnt   = pcnt_q;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DEB_T=4, HOLD_T=10, REP_T=5; a second
// instance with auto-repeat disabled shares the same stimulus.
module tb_key_debounce;

  logic       CLK;
  logic       RST;
  logic       KEY_In;
  logic       KEY_OK, KEY_Release, KEY_Level;
  logic [7:0] Press_Cnt;
  logic       nr_ok, nr_rel, nr_lvl;
  logic [7:0] nr_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int ok_seen = 0;
  int rel_seen = 0;
  int both_seen = 0;
  int ok_base, rel_base;
  bit bounce [10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  logic exp_ok;

  key_debounce #(
    .DEB_T(30'd4), .HOLD_T(30'd10), .REP_T(30'd5), .REPEAT_EN(1'b1)
  ) u_dut (
    .CLK(CLK), .RST(RST), .KEY_In(KEY_In),
    .KEY_OK(KEY_OK), .KEY_Release(KEY_Release),
    .KEY_Level(KEY_Level), .Press_Cnt(Press_Cnt)
  );

  key_debounce #(
    .DEB_T(30'd4), .HOLD_T(30'd10), .REP_T(30'd5), .REPEAT_EN(1'b0)
  ) u_nr (
    .CLK(CLK), .RST(RST), .KEY_In(KEY_In),
    .KEY_OK(nr_ok), .KEY_Release(nr_rel),
    .KEY_Level(nr_lvl), .Press_Cnt(nr_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (KEY_OK === 1'b1) ok_seen++;
    if (KEY_Release === 1'b1) rel_seen++;
    if (KEY_OK === 1'b1 && KEY_Release === 1'b1) both_seen++;
  end

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    KEY_In = 1'b1;
    RST    = 1'b1;
    step(2);
    check("rst_ok",   {31'd0, KEY_OK}, 32'd0);
    check("rst_rel",  {31'd0, KEY_Release}, 32'd0);
    check("rst_lvl",  {31'd0, KEY_Level}, 32'd0);
    check("rst_pcnt", {24'd0, Press_Cnt}, 32'd0);
    RST = 1'b0;
    step(3);

    // glitch: three sampled edges low, then released
    KEY_In = 1'b0;
    step(3);
    KEY_In = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("glitch_ok",  {31'd0, KEY_OK}, 32'd0);
      check("glitch_lvl", {31'd0, KEY_Level}, 32'd0);
    end
    check("glitch_pcnt", {24'd0, Press_Cnt}, 32'd0);

    // clean press: KEY_OK in the cycle after edge 6
    KEY_In = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step(1);
      check("press_early_ok",  {31'd0, KEY_OK}, 32'd0);
      check("press_early_lvl", {31'd0, KEY_Level}, 32'd0);
    end
    step(1);
    check("press_ok",   {31'd0, KEY_OK}, 32'd1);
    check("press_lvl",  {31'd0, KEY_Level}, 32'd1);
    check("press_pcnt", {24'd0, Press_Cnt}, 32'd1);
    step(1);
    check("press_ok_once", {31'd0, KEY_OK}, 32'd0);

    // release with bounce: 1,1,0 then steady 1 from edge e3; release after e9
    for (int i = 0; i < 9; i++) begin
      KEY_In = bounce[i];
      step(1);
      check("bounce_ok",  {31'd0, KEY_OK}, 32'd0);
      check("bounce_rel", {31'd0, KEY_Release}, 32'd0);
      check("bounce_lvl", {31'd0, KEY_Level}, 32'd1);
    end
    KEY_In = bounce[9];
    step(1);
    check("release_rel", {31'd0, KEY_Release}, 32'd1);
    check("release_lvl", {31'd0, KEY_Level}, 32'd0);
    check("release_ok",  {31'd0, KEY_OK}, 32'd0);
    step(1);
    check("release_once", {31'd0, KEY_Release}, 32'd0);
    check("release_pcnt", {24'd0, Press_Cnt}, 32'd1);
    step(3);

    // auto-repeat: pulses at c, c+10, c+15 ... c+40
    KEY_In = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step(1);
      check("rep_pre_ok", {31'd0, KEY_OK}, 32'd0);
    end
    step(1);
    check("rep_first_ok", {31'd0, KEY_OK}, 32'd1);
    check("rep_first_nr", {31'd0, nr_ok}, 32'd1);
    for (int j = 1; j <= 40; j++) begin
      step(1);
      exp_ok = (j >= 10) && (((j - 10) % 5) == 0);
      check("rep_ok",  {31'd0, KEY_OK}, {31'd0, exp_ok});
      check("rep_nr",  {31'd0, nr_ok}, 32'd0);
      check("rep_lvl", {31'd0, KEY_Level}, 32'd1);
    end
    check("rep_pcnt",    {24'd0, Press_Cnt}, 32'd9);
    check("rep_nr_pcnt", {24'd0, nr_cnt}, 32'd2);

    // reset while in REPEAT with key held
    RST = 1'b1;
    step(1);
    check("midrst_ok",      {31'd0, KEY_OK}, 32'd0);
    check("midrst_rel",     {31'd0, KEY_Release}, 32'd0);
    check("midrst_lvl",     {31'd0, KEY_Level}, 32'd0);
    check("midrst_pcnt",    {24'd0, Press_Cnt}, 32'd0);
    check("midrst_nr_pcnt", {24'd0, nr_cnt}, 32'd0);
    RST = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step(1);
      check("midrst_pre_ok", {31'd0, KEY_OK}, 32'd0);
    end
    step(1);
    check("midrst_re_ok",   {31'd0, KEY_OK}, 32'd1);
    check("midrst_re_pcnt", {24'd0, Press_Cnt}, 32'd1);
    check("midrst_re_nr",   {31'd0, nr_ok}, 32'd1);
    KEY_In = 1'b1;
    step(10);
    check("midrst_rel_lvl", {31'd0, KEY_Level}, 32'd0);

    // wrap: 256 clean presses from a fresh reset
    RST = 1'b1;
    step(1);
    RST = 1'b0;
    step(2);
    ok_base  = ok_seen;
    rel_base = rel_seen;
    for (int n = 0; n < 256; n++) begin
      KEY_In = 1'b0;
      step(8);
      KEY_In = 1'b1;
      step(8);
      if (n == 254) check("wrap_255", {24'd0, Press_Cnt}, 32'd255);
    end
    check("wrap_pcnt",    {24'd0, Press_Cnt}, 32'd0);
    check("wrap_nr_pcnt", {24'd0, nr_cnt}, 32'd0);
    check("wrap_ok_pulses",  ok_seen - ok_base, 32'd256);
    check("wrap_rel_pulses", rel_seen - rel_base, 32'd256);
    check("ok_rel_overlap",  both_seen, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
